// File: rtl/id_ex_stage.sv
// Decode stage with ID/EX pipeline register, load-use hazard detection and stall counter.
// Optional write-back bypass into the operand read path is enabled by defining ID_WB_BYPASS_EN.
module id_ex_stage #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_valid,
    input  logic [DW-1:0] if_instr,
    input  logic [DW-1:0] if_pc,
    output logic          if_stall,
    input  logic          flush,
    output logic [AW-1:0] rf_raddr1,
    output logic [AW-1:0] rf_raddr2,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          ex_valid,
    output logic [3:0]    ex_opcode,
    output logic [AW-1:0] ex_rs,
    output logic [AW-1:0] ex_rt,
    output logic [AW-1:0] ex_rd,
    output logic [DW-1:0] ex_op1,
    output logic [DW-1:0] ex_op2,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc,
    output logic          ex_we,
    output logic          ex_mem_rd,
    output logic          ex_mem_wr,
    output logic          ex_branch,
    output logic [15:0]   stall_cnt
);

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_LW    = 4'd4;
    localparam logic [3:0] OP_SW    = 4'd5;
    localparam logic [3:0] OP_BEQ   = 4'd6;

    logic [3:0]    opcode;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] imm;
    logic [DW-1:0] op1, op2;
    logic [AW-1:0] dec_rd;
    logic          dec_we, dec_mem_rd, dec_mem_wr, dec_branch, rt_used;
    logic          load_use;

    assign opcode = if_instr[15:12];
    assign rs     = if_instr[9 +: AW];
    assign rt     = if_instr[6 +: AW];
    assign rd     = if_instr[3 +: AW];
    assign imm    = {{(DW-6){if_instr[5]}}, if_instr[5:0]};

    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    always_comb begin
        dec_we     = 1'b0;
        dec_mem_rd = 1'b0;
        dec_mem_wr = 1'b0;
        dec_branch = 1'b0;
        dec_rd     = '0;
        rt_used    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_we  = 1'b1;
                dec_rd  = rd;
                rt_used = 1'b1;
            end
            OP_ADDI: begin
                dec_we = 1'b1;
                dec_rd = rt;
            end
            OP_LW: begin
                dec_we     = 1'b1;
                dec_mem_rd = 1'b1;
                dec_rd     = rt;
            end
            OP_SW: begin
                dec_mem_wr = 1'b1;
                rt_used    = 1'b1;
            end
            OP_BEQ: begin
                dec_branch = 1'b1;
                rt_used    = 1'b1;
            end
            default: ;
        endcase
    end

    // r0 is hardwired to zero and wins over any bypassed write-back value
`ifdef ID_WB_BYPASS_EN
    logic byp1, byp2;
    assign byp1 = wb_we && (wb_addr != '0) && (wb_addr == rs);
    assign byp2 = wb_we && (wb_addr != '0) && (wb_addr == rt);
    assign op1  = (rs == '0) ? '0 : (byp1 ? wb_data : rf_rdata1);
    assign op2  = (rt == '0) ? '0 : (byp2 ? wb_data : rf_rdata2);
`else
    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_addr, wb_data};
    assign op1 = (rs == '0) ? '0 : rf_rdata1;
    assign op2 = (rt == '0) ? '0 : rf_rdata2;
`endif

    assign load_use = if_valid && ex_valid && ex_mem_rd && (ex_rd != '0) &&
                      ((ex_rd == rs) || ((ex_rd == rt) && rt_used));
    assign if_stall = rst && !flush && load_use;

    // A stall or flush inserts a bubble; only valid and control bits matter then
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid  <= 1'b0;
            ex_opcode <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_op1    <= '0;
            ex_op2    <= '0;
            ex_imm    <= '0;
            ex_pc     <= '0;
            ex_we     <= 1'b0;
            ex_mem_rd <= 1'b0;
            ex_mem_wr <= 1'b0;
            ex_branch <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (flush || if_stall) begin
                ex_valid  <= 1'b0;
                ex_we     <= 1'b0;
                ex_mem_rd <= 1'b0;
                ex_mem_wr <= 1'b0;
                ex_branch <= 1'b0;
            end else begin
                ex_valid  <= if_valid;
                ex_opcode <= opcode;
                ex_rs     <= rs;
                ex_rt     <= rt;
                ex_rd     <= dec_rd;
                ex_op1    <= op1;
                ex_op2    <= op2;
                ex_imm    <= imm;
                ex_pc     <= if_pc;
                ex_we     <= if_valid && dec_we;
                ex_mem_rd <= if_valid && dec_mem_rd;
                ex_mem_wr <= if_valid && dec_mem_wr;
                ex_branch <= if_valid && dec_branch;
            end
            if (if_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule
